uart_baud_ctrl: RTL and testbench
=================================

# uart_baud_ctrl

Baud-rate controller and tick scheduler for the UART: it owns the active divisor, produces the oversampling tick (`sample_tick`) and the bit tick (`bit_tick`) consumed by the TX/RX engines, and accepts runtime divisor changes through a valid/ready config port. A new divisor is deferred until the serial link is idle, so a frame in flight is never retimed. It replaces free-running toggled clocks with single-cycle enables in the `clk` domain.

## Interface
- `DVSR_W`, 16, width of divisor and counters
- `SAMPLE`, 16, sample ticks per bit (power of 2, ≥2)
- `RESET_DVSR`, 651, divisor after reset (100 MHz / (16·9600))
- `clk`  in  1  system clock, all logic on rising edge
- `reset`  in  1  synchronous, active-high reset
- `enable`  in  1  tick generation enable
- `link_busy`  in  1  OR of TX-busy and RX-busy; high blocks divisor update
- `sync_clr`  in  1  RX start-edge pulse; re-phases counters
- `cfg_valid`  in  1  divisor write request
- `cfg_dvsr`  in  DVSR_W  requested sample divisor (clk cycles per sample_tick)
- `cfg_ready`  out  1  high when no update is pending
- `cfg_err`  out  1  1-cycle pulse: accepted write rejected as illegal
- `cfg_applied`  out  1  1-cycle pulse: pending divisor became active
- `cur_dvsr`  out  DVSR_W  active divisor
- `sample_tick`  out  1  1-cycle pulse every `cur_dvsr` cycles
- `bit_tick`  out  1  1-cycle pulse every `SAMPLE` sample ticks, coincident with a sample_tick

## Operation
- State: OFF (enable=0), RUN (counting), plus independent pending flag `pend` with register `pend_dvsr`.
- Handshake: `cfg_ready = ~pend`. Write accepted on edge with `cfg_valid & cfg_ready`. `cfg_dvsr` < 2: `cfg_err` pulses next cycle, nothing stored, `cfg_ready` stays 1. Otherwise `pend<=1`, `pend_dvsr<=cfg_dvsr`.
- Apply: on any edge with `pend=1` and `link_busy=0`: `cur_dvsr<=pend_dvsr`, `pend<=0`, `sample_cnt<=0`, `bit_cnt<=0`, `cfg_applied<=1`, no tick that cycle. Independent of `enable`.
- Count (RUN, no apply, no sync_clr): if `sample_cnt == cur_dvsr-1` then `sample_cnt<=0`, `sample_tick<=1`, `bit_cnt<=bit_cnt+1` (wraps at SAMPLE-1 → 0 with `bit_tick<=1`); else `sample_cnt<=sample_cnt+1`, ticks 0.
- `sync_clr`: `sample_cnt<=0`, `bit_cnt<=0`, ticks 0.
- OFF: counters forced to 0, ticks 0; config port and apply still operate.
- Priority per edge: reset > apply > sync_clr > OFF > count.
- Counters are unsigned DVSR_W and $clog2(SAMPLE) bits; compare against `cur_dvsr-1`, never overflow because `cur_dvsr` ≥ 2.

## Timing
- Reset values: `cur_dvsr=RESET_DVSR`, `cfg_ready=1`, `pend=0`, counters 0, `sample_tick=bit_tick=cfg_err=cfg_applied=0`. Reset mid-pending discards the pending divisor.
- All outputs registered; `cfg_ready` is a direct flop output (combinationally `~pend`).
- First `sample_tick` after enable rise/apply/sync_clr: high in the cycle after the `cur_dvsr`-th counting edge; period `cur_dvsr` thereafter. `bit_tick` period `cur_dvsr·SAMPLE`.
- Accept at edge N with `link_busy=0` at edge N+1 → `cfg_applied` and new `cur_dvsr` visible after edge N+1 (latency 2 edges from request to visible). Accept and apply never occur on the same edge.
- `link_busy` high holds the update indefinitely; `cfg_ready` stays 0; ticks continue on old divisor.
- `cfg_valid` while `cfg_ready=0`: ignored, requester must hold.
- `sync_clr` and apply same edge: apply wins (both clear counters anyway).
- `enable` falling mid-bit: partial counts lost; restart from 0.

## Test plan
- Reset, enable=1, SAMPLE=16, RESET_DVSR=4 → sample_tick every 4 cycles, first 4 cycles after enable; bit_tick every 64, with sample_tick.
- Write 10 with link_busy=1 for 50 cycles → cfg_ready=0, ticks stay at period 4; drop link_busy → cfg_applied one pulse, cur_dvsr=10, next tick 10 cycles later.
- Write 1 and 0 → cfg_err pulse each, cur_dvsr unchanged, cfg_ready remains 1.
- Back-to-back cfg_valid (6 then 8) with link_busy=1 → only 6 accepted; 8 accepted only after first apply; final cur_dvsr=8.
- sync_clr at sample_cnt=2 (dvsr 4) → no tick, next sample_tick 4 cycles later, bit_cnt restarted.
- reset asserted with pending write → after reset cur_dvsr=RESET_DVSR, cfg_ready=1, no cfg_applied.

Source files
------------

// File: rtl/uart_baud_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : uart_baud_ctrl_if                                      |
// | Description : Control/config bundle between a UART and its baud      |
// |               controller. The master modport drives the link status  |
// |               and divisor writes. The slave modport is the           |
// |               controller, which returns the ticks and status.        |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
interface uart_baud_ctrl_if #(
  parameter int DVSR_W = 16
);
  logic              enable;
  logic              link_busy;
  logic              sync_clr;
  logic              cfg_valid;
  logic [DVSR_W-1:0] cfg_dvsr;
  logic              cfg_ready;
  logic              cfg_err;
  logic              cfg_applied;
  logic [DVSR_W-1:0] cur_dvsr;
  logic              sample_tick;
  logic              bit_tick;

  modport master (
    output enable, link_busy, sync_clr, cfg_valid, cfg_dvsr,
    input  cfg_ready, cfg_err, cfg_applied, cur_dvsr, sample_tick, bit_tick
  );

  modport slave (
    input  enable, link_busy, sync_clr, cfg_valid, cfg_dvsr,
    output cfg_ready, cfg_err, cfg_applied, cur_dvsr, sample_tick, bit_tick
  );
endinterface
`default_nettype wire

// File: rtl/uart_baud_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : uart_baud_ctrl                                         |
// | Description : Baud-rate controller. It holds the active divisor and  |
// |               generates single-cycle sample_tick and bit_tick        |
// |               enables. Divisor writes wait until the link is idle.   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module uart_baud_ctrl #(
  parameter int DVSR_W     = 16,
  parameter int SAMPLE     = 16,
  parameter int RESET_DVSR = 651
) (
  input  logic           clk,
  input  logic           reset,
  uart_baud_ctrl_if.slave bus
);

  localparam int                BIT_W        = $clog2(SAMPLE);
  localparam logic [DVSR_W-1:0] c_RESET_DVSR = DVSR_W'(RESET_DVSR);
  localparam logic [DVSR_W-1:0] c_MIN_DVSR   = DVSR_W'(2);
  localparam logic [DVSR_W-1:0] c_DVSR_ONE   = DVSR_W'(1);
  localparam logic [BIT_W-1:0]  c_BIT_LAST   = BIT_W'(SAMPLE - 1);
  localparam logic [BIT_W-1:0]  c_BIT_ONE    = BIT_W'(1);

  logic [DVSR_W-1:0] cur_dvsr_q,   cur_dvsr_d;
  logic [DVSR_W-1:0] pend_dvsr_q,  pend_dvsr_d;
  logic [DVSR_W-1:0] sample_cnt_q, sample_cnt_d;
  logic [BIT_W-1:0]  bit_cnt_q,    bit_cnt_d;
  logic              pend_q,        pend_d;
  logic              cfg_ready_q,   cfg_ready_d;
  logic              cfg_err_q,     cfg_err_d;
  logic              cfg_applied_q, cfg_applied_d;
  logic              sample_tick_q, sample_tick_d;
  logic              bit_tick_q,    bit_tick_d;

  // Accept and apply are mutually exclusive because one needs pend low
  // and the other needs pend high.
  logic w_accept;
  logic w_illegal;
  logic w_apply;
  logic w_sample_wrap;
  logic w_bit_wrap;

  assign w_accept      = bus.cfg_valid & cfg_ready_q;
  assign w_illegal     = bus.cfg_dvsr < c_MIN_DVSR;
  assign w_apply       = pend_q & ~bus.link_busy;
  assign w_sample_wrap = (sample_cnt_q == (cur_dvsr_q - c_DVSR_ONE));
  assign w_bit_wrap    = (bit_cnt_q == c_BIT_LAST);

  // Next-state logic, priority apply > sync_clr > off (enable low) > count.
  always_comb begin
    cur_dvsr_d    = cur_dvsr_q;
    pend_d        = pend_q;
    pend_dvsr_d   = pend_dvsr_q;
    sample_cnt_d  = sample_cnt_q;
    bit_cnt_d     = bit_cnt_q;
    cfg_err_d     = 1'b0;
    cfg_applied_d = 1'b0;
    sample_tick_d = 1'b0;
    bit_tick_d    = 1'b0;

    if (w_apply) begin
      // New divisor starts from a clean phase, so no tick in this cycle.
      cur_dvsr_d    = pend_dvsr_q;
      pend_d        = 1'b0;
      sample_cnt_d  = '0;
      bit_cnt_d     = '0;
      cfg_applied_d = 1'b1;
    end else begin
      if (w_accept) begin
        if (w_illegal) begin
          cfg_err_d = 1'b1;
        end else begin
          pend_d      = 1'b1;
          pend_dvsr_d = bus.cfg_dvsr;
        end
      end

      if (bus.sync_clr || !bus.enable) begin
        sample_cnt_d = '0;
        bit_cnt_d    = '0;
      end else if (w_sample_wrap) begin
        sample_cnt_d  = '0;
        sample_tick_d = 1'b1;
        if (w_bit_wrap) begin
          bit_cnt_d  = '0;
          bit_tick_d = 1'b1;
        end else begin
          bit_cnt_d = bit_cnt_q + c_BIT_ONE;
        end
      end else begin
        sample_cnt_d = sample_cnt_q + c_DVSR_ONE;
      end
    end

    // cfg_ready is kept as its own flop so that the output is registered.
    cfg_ready_d = ~pend_d;
  end

  // State and output registers, with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_dvsr_q    <= c_RESET_DVSR;
      pend_q        <= 1'b0;
      pend_dvsr_q   <= '0;
      sample_cnt_q  <= '0;
      bit_cnt_q     <= '0;
      cfg_ready_q   <= 1'b1;
      cfg_err_q     <= 1'b0;
      cfg_applied_q <= 1'b0;
      sample_tick_q <= 1'b0;
      bit_tick_q    <= 1'b0;
    end else begin
      cur_dvsr_q    <= cur_dvsr_d;
      pend_q        <= pend_d;
      pend_dvsr_q   <= pend_dvsr_d;
      sample_cnt_q  <= sample_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      cfg_ready_q   <= cfg_ready_d;
      cfg_err_q     <= cfg_err_d;
      cfg_applied_q <= cfg_applied_d;
      sample_tick_q <= sample_tick_d;
      bit_tick_q    <= bit_tick_d;
    end
  end

  assign bus.cfg_ready   = cfg_ready_q;
  assign bus.cfg_err     = cfg_err_q;
  assign bus.cfg_applied = cfg_applied_q;
  assign bus.cur_dvsr    = cur_dvsr_q;
  assign bus.sample_tick = sample_tick_q;
  assign bus.bit_tick    = bit_tick_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_baud_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_uart_baud_ctrl                                      |
// | Description : Self-checking bench for uart_baud_ctrl. It uses a      |
// |               vector table, directed corner sequences and random     |
// |               traffic checked against a tick-phase reference model. |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_uart_baud_ctrl;

  localparam int DVSR_W     = 16;
  localparam int SAMPLE     = 16;
  localparam int RESET_DVSR = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  uart_baud_ctrl_if #(.DVSR_W(DVSR_W)) bus ();

  uart_baud_ctrl #(
    .DVSR_W    (DVSR_W),
    .SAMPLE    (SAMPLE),
    .RESET_DVSR(RESET_DVSR)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model. m_t counts the counting edges since the last phase
  // restart. A sample tick falls on every multiple of the divisor, and a
  // bit tick falls on every multiple of divisor*SAMPLE.
  int     m_cur  = RESET_DVSR;
  bit     m_pend = 1'b0;
  int     m_pdv  = 0;
  longint m_t    = 0;
  bit     m_ready, m_err, m_app, m_st, m_bt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input bit rst, input bit en, input bit busy, input bit sc,
                        input bit v, input int dv);
    reset         = rst;
    bus.enable    = en;
    bus.link_busy = busy;
    bus.sync_clr  = sc;
    bus.cfg_valid = v;
    bus.cfg_dvsr  = DVSR_W'(dv);
  endtask

  task automatic model_edge();
    bit old_pend = m_pend;
    m_err = 0; m_app = 0; m_st = 0; m_bt = 0;
    if (reset) begin
      m_cur = RESET_DVSR; m_pend = 0; m_t = 0;
    end else if (old_pend && !bus.link_busy) begin
      m_cur = m_pdv; m_pend = 0; m_t = 0; m_app = 1;
    end else begin
      if (!old_pend && bus.cfg_valid) begin
        if (int'(bus.cfg_dvsr) < 2) m_err = 1;
        else begin m_pend = 1; m_pdv = int'(bus.cfg_dvsr); end
      end
      if (bus.sync_clr || !bus.enable) m_t = 0;
      else begin
        m_t++;
        m_st = (m_t % m_cur) == 0;
        m_bt = (m_t % (m_cur * SAMPLE)) == 0;
      end
    end
    m_ready = !m_pend;
  endtask

  // Advance one clock. The model is updated with the inputs that were
  // present at the edge. The DUT outputs are then compared 1 ns later.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("model_ready",   32'(bus.cfg_ready),   32'(m_ready));
    check("model_err",     32'(bus.cfg_err),     32'(m_err));
    check("model_applied", 32'(bus.cfg_applied), 32'(m_app));
    check("model_cur",     32'(bus.cur_dvsr),    32'(m_cur));
    check("model_stick",   32'(bus.sample_tick), 32'(m_st));
    check("model_btick",   32'(bus.bit_tick),    32'(m_bt));
  endtask

  // Steps until the selected tick is seen, up to limit steps.
  task automatic wait_tick(input bit want_bt, input int limit, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!(want_bt ? bus.bit_tick : bus.sample_tick) && n < limit);
  endtask

  typedef struct {
    bit rst, en, busy, sc, v;
    int dv;
    bit ready, err, app;
    int cur;
    bit st, bt;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int n, cnt_st, cnt_bt, first_st, first_bt;

    //        rst en bsy sc v  dv   rdy err app cur st bt
    tbl[0] = '{1, 0, 0, 0, 0, 0,   1,  0,  0,  4,  0, 0};
    tbl[1] = '{0, 0, 0, 0, 1, 1,   1,  1,  0,  4,  0, 0};
    tbl[2] = '{0, 0, 0, 0, 1, 0,   1,  1,  0,  4,  0, 0};
    tbl[3] = '{0, 0, 0, 0, 0, 0,   1,  0,  0,  4,  0, 0};
    tbl[4] = '{0, 0, 1, 0, 1, 7,   0,  0,  0,  4,  0, 0};
    tbl[5] = '{0, 0, 1, 0, 0, 0,   0,  0,  0,  4,  0, 0};
    tbl[6] = '{0, 0, 0, 0, 0, 0,   1,  0,  1,  7,  0, 0};
    tbl[7] = '{0, 0, 0, 0, 0, 0,   1,  0,  0,  7,  0, 0};

    set_in(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      set_in(tbl[i].rst, tbl[i].en, tbl[i].busy, tbl[i].sc, tbl[i].v, tbl[i].dv);
      step();
      check($sformatf("tbl%0d_ready", i), 32'(bus.cfg_ready),   32'(tbl[i].ready));
      check($sformatf("tbl%0d_err", i),   32'(bus.cfg_err),     32'(tbl[i].err));
      check($sformatf("tbl%0d_app", i),   32'(bus.cfg_applied), 32'(tbl[i].app));
      check($sformatf("tbl%0d_cur", i),   32'(bus.cur_dvsr),    32'(tbl[i].cur));
      check($sformatf("tbl%0d_st", i),    32'(bus.sample_tick), 32'(tbl[i].st));
      check($sformatf("tbl%0d_bt", i),    32'(bus.bit_tick),    32'(tbl[i].bt));
    end

    // Tick cadence after reset, with divisor 4.
    set_in(1, 0, 0, 0, 0, 0); step();
    set_in(0, 1, 0, 0, 0, 0);
    cnt_st = 0; cnt_bt = 0; first_st = 0; first_bt = 0;
    for (int k = 1; k <= 130; k++) begin
      step();
      if (bus.sample_tick) begin cnt_st++; if (first_st == 0) first_st = k; end
      if (bus.bit_tick)    begin cnt_bt++; if (first_bt == 0) first_bt = k; end
    end
    check("first_sample_tick", 32'(first_st), 32'd4);
    check("first_bit_tick",    32'(first_bt), 32'd64);
    check("sample_tick_count", 32'(cnt_st),   32'd32);
    check("bit_tick_count",    32'(cnt_bt),   32'd2);

    // A write stays pending while the link is busy, and ticks keep the old
    // period during that time.
    set_in(0, 1, 1, 0, 1, 10); step();
    set_in(0, 1, 1, 0, 0, 0);
    step();
    cnt_st = 0;
    for (int k = 0; k < 48; k++) begin
      step();
      if (bus.sample_tick) cnt_st++;
    end
    check("busy_ready_low",  32'(bus.cfg_ready), 32'd0);
    check("busy_tick_count", 32'(cnt_st),        32'd12);
    check("busy_cur_old",    32'(bus.cur_dvsr),  32'd4);
    set_in(0, 1, 0, 0, 0, 0); step();
    check("apply_pulse", 32'(bus.cfg_applied), 32'd1);
    check("apply_cur10", 32'(bus.cur_dvsr),    32'd10);
    wait_tick(0, 40, n);
    check("tick_after_apply", 32'(n), 32'd10);

    // Illegal divisors are rejected without changing any state.
    set_in(0, 1, 0, 0, 1, 1); step();
    check("err_dv1",   32'(bus.cfg_err),   32'd1);
    check("err_ready", 32'(bus.cfg_ready), 32'd1);
    set_in(0, 1, 0, 0, 1, 0); step();
    check("err_dv0",   32'(bus.cfg_err),  32'd1);
    check("err_cur",   32'(bus.cur_dvsr), 32'd10);
    set_in(0, 1, 0, 0, 0, 0); step();
    check("err_one_cycle", 32'(bus.cfg_err), 32'd0);

    // Back-to-back writes. The second one is ignored until the first has
    // been applied.
    set_in(0, 1, 1, 0, 1, 6); step();
    set_in(0, 1, 1, 0, 1, 8); step(); step(); step();
    check("b2b_hold_cur", 32'(bus.cur_dvsr), 32'd10);
    set_in(0, 1, 0, 0, 1, 8); step();
    check("b2b_first_apply", 32'(bus.cur_dvsr), 32'd6);
    step();
    check("b2b_second_accept", 32'(bus.cfg_ready), 32'd0);
    set_in(0, 1, 0, 0, 0, 0); step();
    check("b2b_final_cur", 32'(bus.cur_dvsr), 32'd8);

    // sync_clr mid-sample re-phases both counters.
    set_in(1, 1, 0, 0, 0, 0); step();
    set_in(0, 1, 0, 0, 0, 0); step(); step();
    set_in(0, 1, 0, 1, 0, 0); step();
    check("sync_no_tick", 32'(bus.sample_tick), 32'd0);
    set_in(0, 1, 0, 0, 0, 0);
    wait_tick(0, 40, n);
    check("sync_next_tick", 32'(n), 32'd4);
    wait_tick(1, 200, n);
    check("sync_next_bit", 32'(n), 32'd60);

    // A reset during a pending write discards the pending divisor.
    set_in(0, 1, 1, 0, 1, 9); step();
    set_in(0, 1, 1, 0, 0, 0); step();
    set_in(1, 1, 0, 0, 0, 0); step();
    set_in(0, 1, 0, 0, 0, 0);
    cnt_st = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (bus.cfg_applied) cnt_st++;
    end
    check("rst_pend_cur",     32'(bus.cur_dvsr),  32'(RESET_DVSR));
    check("rst_pend_ready",   32'(bus.cfg_ready), 32'd1);
    check("rst_pend_applied", 32'(cnt_st),        32'd0);

    // Random traffic checked against the model.
    for (int k = 0; k < 4000; k++) begin
      set_in($urandom_range(0, 199) == 0,
             $urandom_range(0, 19) != 0,
             $urandom_range(0, 9) < 4,
             $urandom_range(0, 49) == 0,
             $urandom_range(0, 9) < 2,
             int'($urandom_range(0, 12)));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
